fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the MIPS core. Owns the architectural PC, issues one request at a time to the instruction memory over a req/ack handshake and holds the fetched word for decode. Applies branch/jump redirects from decode and honours a downstream stall. Sits between the `ifu` instruction memory and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stall`  in  1  decode cannot accept; hold the current instruction.
- `isBranch`  in  1  taken branch for the instruction being consumed.
- `branchAddr`  in  32  branch target.
- `isJump`  in  1  jump for the instruction being consumed.
- `jumpAddr`  in  32  jump target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ack`  in  1  memory data valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `PC`  out  32  address of `instructure`.
- `instructure`  out  32  fetched instruction.
- `instr_valid`  out  1  `PC`/`instructure` valid for decode.

## Operation
- States: IDLE, FETCH, VALID.
- IDLE: one cycle after reset release, then FETCH. Outputs quiet.
- FETCH: `imem_req`=1, `imem_addr`=fetch address; address held stable until ack. On `imem_ack`: register `imem_rdata` into `instructure`, fetch address into `PC`, go to VALID.
- VALID: `instr_valid`=1. With `stall`=1: hold everything, no request. With `stall`=0: instruction consumed; compute next fetch address, go to FETCH.
- Next address on consume: `isJump` → `jumpAddr`; else `isBranch` → `branchAddr`; else `PC`+4. Jump wins over branch when both set.
- Redirect inputs are sampled only on consume (VALID, `stall`=0); ignored otherwise.
- Targets have bits [1:0] forced to 0. `PC`+4 wraps modulo 2^32.
- `imem_ack` ignored outside FETCH.

## Timing
- Reset values: `PC`=`RESET_PC`, `instructure`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, state IDLE, pending-redirect cleared.
- Reset asserted mid-fetch: `imem_req` drops immediately (async); an ack arriving after release while in IDLE is dropped.
- Cycle 0 after release: IDLE. Cycle 1: FETCH, `imem_req`=1 at `RESET_PC`. Zero-wait memory (ack same cycle) → `instr_valid` in cycle 2.
- Latency: ack cycle +1 to `instr_valid`. Throughput with zero-wait memory and no stall: one instruction per 2 cycles.
- N wait states add N cycles; `imem_addr` constant throughout.

## Configuration
- `FETCH_CTRL_DELAY_SLOT_EN` defined: MIPS branch delay slot. Redirect on consume of X fetches X+4 next and latches the target as pending; on consume of the delay slot the pending target is fetched and the delay slot's own redirect inputs are ignored. Reset clears pending.
- Undefined: no delay slot; consume with redirect fetches the target directly; no pending register.

## Structure
- Shared header `defines.v`: state encodings, `RESET_PC` default, instruction width constant.
- One sub-module natural: `fetch_npc`, combinational next-address select (jump/branch/pending/PC+4, alignment forcing).

## Test plan
- Reset 20 ns high then low, zero-wait memory returning `{addr}` → `instr_valid` every 2nd cycle with `PC` 0x3000, 0x3004, 0x3008, `instructure` equal to `PC`.
- Ack delayed 3 cycles on 0x3004 → `imem_req` high 4 cycles, `imem_addr` stable 0x3004, `instr_valid` rises the cycle after ack.
- `stall` high 4 cycles while VALID at 0x3008 → `PC`, `instructure` unchanged, `imem_req`=0; release → fetch 0x300C.
- `isJump` with `jumpAddr`=0x3100 on consume of 0x300C → next `PC` 0x3100 (macro off); 0x3010 then 0x3100 (macro on).
- `isBranch` 0x3203 and `isJump` 0x3400 together → next `PC` 0x3400; `isBranch` alone with 0x3203 → 0x3200.
- Reset asserted during a wait state, ack pulsed one cycle after release → ack ignored, fetch restarts at 0x3000, `instr_valid` 0 until that fetch completes.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch sequencer: state encodings, reset PC, word width.
// Optional build macro: FETCH_CTRL_DELAY_SLOT_EN (MIPS branch delay slot).
package fetch_ctrl_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// fetch_npc: combinational next-fetch-address select (jump > branch > sequential, plus pending target).
// Optional build macro: FETCH_CTRL_DELAY_SLOT_EN adds the pending-target input and redirect outputs.
module fetch_npc
    import fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        isBranch,
    input  logic [31:0] branchAddr,
    input  logic        isJump,
    input  logic [31:0] jumpAddr,
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    input  logic        pendingValid,
    input  logic [31:0] pendingAddr,
    output logic        redirect,
    output logic [31:0] targetAddr,
`endif
    output logic [31:0] nextAddr
);

    logic        takeRedirect;
    logic [31:0] target;
    logic [31:0] seqAddr;

    assign takeRedirect = isJump | isBranch;
    assign target       = alignWord(isJump ? jumpAddr : branchAddr);
    assign seqAddr      = pc + 32'd4;

`ifdef FETCH_CTRL_DELAY_SLOT_EN
    // The delay slot is always fetched sequentially; the target waits one instruction.
    assign redirect   = takeRedirect;
    assign targetAddr = target;
    assign nextAddr   = pendingValid ? pendingAddr : seqAddr;
`else
    assign nextAddr   = takeRedirect ? target : seqAddr;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, runs one req/ack fetch at a time and holds the word for decode.
// Optional build macro: FETCH_CTRL_DELAY_SLOT_EN enables MIPS branch-delay-slot sequencing.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               isBranch,
    input  logic [31:0]        branchAddr,
    input  logic               isJump,
    input  logic [31:0]        jumpAddr,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [31:0]        PC,
    output logic [INSTR_W-1:0] instructure,
    output logic               instr_valid
);

    logic [1:0]  state;
    logic [31:0] fetchAddr;
    logic [31:0] nextAddr;
    logic        consume;

    assign consume     = (state == VALID) && !stall;
    // NOTE: req is decoded from state, so an asynchronous reset drops it without waiting for a clock edge.
    assign imem_req    = (state == FETCH);
    assign imem_addr   = fetchAddr;
    assign instr_valid = (state == VALID);

`ifdef FETCH_CTRL_DELAY_SLOT_EN
    logic        pendingValid;
    logic [31:0] pendingAddr;
    logic        redirect;
    logic [31:0] targetAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendingValid <= 1'b0;
            pendingAddr  <= '0;
        end else if (consume) begin
            if (pendingValid) begin
                pendingValid <= 1'b0;
            end else if (redirect) begin
                pendingValid <= 1'b1;
                pendingAddr  <= targetAddr;
            end
        end
    end
`endif

    fetch_npc uNpc (
        .pc          (PC),
        .isBranch    (isBranch),
        .branchAddr  (branchAddr),
        .isJump      (isJump),
        .jumpAddr    (jumpAddr),
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        .pendingValid(pendingValid),
        .pendingAddr (pendingAddr),
        .redirect    (redirect),
        .targetAddr  (targetAddr),
`endif
        .nextAddr    (nextAddr)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fetchAddr   <= RESET_PC;
            PC          <= RESET_PC;
            instructure <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        instructure <= imem_rdata;
                        PC          <= fetchAddr;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (consume) begin
                        fetchAddr <= nextAddr;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: random stalls, redirects and memory wait states against a PC-sequence model.
// Honours FETCH_CTRL_DELAY_SLOT_EN to select the delay-slot reference behaviour.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        isBranch;
    logic [31:0] branchAddr;
    logic        isJump;
    logic [31:0] jumpAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] instructure;
    logic        instr_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard / model state
    logic [31:0] expQ[$];
    logic [31:0] modelPC;
    logic [31:0] modelInstr;
    logic        prevValid;
    logic        run;
    logic        pulseAck;
    int          cyc;
    int          lastAckCyc;
    int          consumes;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    logic        pendValid;
    logic [31:0] pendTarget;
`endif

    // Memory model state
    logic busy;
    int   waitLeft;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .isBranch   (isBranch),
        .branchAddr (branchAddr),
        .isJump     (isJump),
        .jumpAddr   (jumpAddr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PC         (PC),
        .instructure(instructure),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Memory contents differ from the address so PC and instruction paths cannot be confused.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic flagFail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic startModel();
        expQ.delete();
        expQ.push_back(RESET_PC);
        prevValid  = 1'b0;
        cyc        = 0;
        lastAckCyc = -100;
        consumes   = 0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        pendValid  = 1'b0;
        pendTarget = '0;
`endif
    endtask

    // Decode-side stimulus
    always @(posedge clk) begin
        #1;
        if (run) begin
            stall      = ($urandom_range(0, 2) == 0);
            isJump     = ($urandom_range(0, 4) == 0);
            isBranch   = ($urandom_range(0, 3) == 0);
            jumpAddr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                     : 32'($urandom);
            branchAddr = 32'($urandom);
        end else begin
            stall      = 1'b0;
            isJump     = 1'b0;
            isBranch   = 1'b0;
            jumpAddr   = '0;
            branchAddr = '0;
        end
    end

    // Instruction memory with 0..3 random wait states and spurious acks while idle
    always @(posedge clk) begin
        #1;
        if (!run) begin
            imem_ack   = pulseAck;
            imem_rdata = 32'hDEAD_BEEF;
            busy       = 1'b0;
        end else if (imem_req) begin
            if (!busy) begin
                busy     = 1'b1;
                waitLeft = $urandom_range(0, 3);
            end
            if (waitLeft == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memWord(imem_addr);
                busy       = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'($urandom);
                waitLeft--;
            end
        end else begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            imem_rdata = 32'($urandom);
            busy       = 1'b0;
        end
    end

    // Monitor: compares presented instructions with the scoreboard and models consumption
    always @(negedge clk) begin
        logic [31:0] exp;
        logic [31:0] tgt;
        logic [31:0] nxt;
        if (run) begin
            cyc++;
            if (imem_req && imem_ack) lastAckCyc = cyc;
            if (imem_req) begin
                if (expQ.size() == 0) flagFail("fetch with no expected address");
                else check("imem_addr", imem_addr, expQ[0]);
            end
            if (instr_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    flagFail("unexpected instruction presented");
                end else begin
                    exp        = expQ.pop_front();
                    modelPC    = exp;
                    modelInstr = memWord(exp);
                    check("PC", PC, modelPC);
                    check("instructure", instructure, modelInstr);
                end
                check("ack-to-valid cycle", 32'(cyc), 32'(lastAckCyc + 1));
            end else if (instr_valid) begin
                check("held PC", PC, modelPC);
                check("held instructure", instructure, modelInstr);
            end
            if (instr_valid) check("imem_req while valid", {31'b0, imem_req}, 32'd0);
            if (instr_valid && !stall) begin
                tgt = (isJump ? jumpAddr : branchAddr) & 32'hFFFF_FFFC;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
                if (pendValid) begin
                    nxt       = pendTarget;
                    pendValid = 1'b0;
                end else begin
                    nxt = modelPC + 32'd4;
                    if (isJump || isBranch) begin
                        pendValid  = 1'b1;
                        pendTarget = tgt;
                    end
                end
`else
                nxt = (isJump || isBranch) ? tgt : modelPC + 32'd4;
`endif
                expQ.push_back(nxt);
                consumes++;
            end
            prevValid = instr_valid;
        end
    end

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        pulseAck   = 1'b0;
        stall      = 1'b0;
        isJump     = 1'b0;
        isBranch   = 1'b0;
        jumpAddr   = '0;
        branchAddr = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        busy       = 1'b0;
        waitLeft   = 0;
        modelPC    = RESET_PC;
        modelInstr = '0;
        startModel();

        #20;
        check("reset PC", PC, RESET_PC);
        check("reset instructure", instructure, 32'd0);
        check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        check("reset imem_addr", imem_addr, RESET_PC);

        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("IDLE cycle imem_req", {31'b0, imem_req}, 32'd0);
        startModel();
        #1 run = 1'b1;
        @(negedge clk);
        check("first fetch imem_req", {31'b0, imem_req}, 32'd1);
        check("first fetch imem_addr", imem_addr, RESET_PC);

        for (int i = 0; i < 6000 && consumes < 300; i++) @(negedge clk);
        if (consumes < 300) flagFail("timeout waiting for random consumes");

        // Reset during a wait state, then an ack one cycle after release
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        @(negedge clk);
        check("stuck fetch imem_req", {31'b0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset imem_req", {31'b0, imem_req}, 32'd0);
        check("async reset instr_valid", {31'b0, instr_valid}, 32'd0);
        check("async reset PC", PC, RESET_PC);
        check("async reset imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        pulseAck = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post-reset IDLE imem_req", {31'b0, imem_req}, 32'd0);
        pulseAck = 1'b0;
        @(negedge clk);
        check("restart imem_req", {31'b0, imem_req}, 32'd1);
        check("restart imem_addr", imem_addr, RESET_PC);
        check("restart instr_valid", {31'b0, instr_valid}, 32'd0);
        startModel();
        #1 run = 1'b1;

        for (int i = 0; i < 3000 && consumes < 100; i++) @(negedge clk);
        if (consumes < 100) flagFail("timeout waiting for consumes after reset");

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
